// File: rtl/seq_match_pkg.sv
// Shared types and sizing for the serial pattern-match controller.
// Contents:
//   state_t     controller state encoding (IDLE / ARMED / DONE)
//   *_DEF       default pattern / counter widths
//   fill_w()    width of a fill counter that counts 0..pat_w
package seq_match_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int unsigned PAT_W_DEF  = 5;
    localparam int unsigned CNT_W_DEF  = 8;
    localparam int unsigned FILL_W_DEF = $clog2(PAT_W_DEF + 1);

    // Fill counter must hold the value pat_w itself
    function automatic int unsigned fill_w(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_window_cmp.sv
// Serial window: shift register, saturating fill counter and pattern compare.
// Ports:
//   clock, reset   rising-edge clock, async active-low reset
//   shift_en       accept bit_in this cycle
//   clr            empty the window (dominates shift_en)
//   bit_in         serial data bit, shifted into window[0]
//   pattern        target pattern, MSB = oldest bit
//   hit            post-shift window is full and equals pattern (combinational)
//   window         current window contents (registered)
// Build option: SEQ_MATCH_NONOVERLAP_EN makes every hit empty the fill counter.
module seq_window_cmp
    import seq_match_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit,
    output logic [PAT_W-1:0] window
);

    localparam int unsigned FILL_W = fill_w(PAT_W);

    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;
    logic [PAT_W-1:0]  win_nxt;

    // Post-shift view: the match decision uses the bit arriving this cycle
    always_comb begin
        win_nxt  = {window[PAT_W-2:0], bit_in};
        fill_nxt = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
    end

    assign hit = shift_en && (fill_nxt == FILL_W'(PAT_W)) && (win_nxt == pattern);

    // Window and fill state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            window <= '0;
            fill   <= '0;
        end else if (clr) begin
            window <= '0;
            fill   <= '0;
        end else if (shift_en) begin
            window <= win_nxt;
`ifdef SEQ_MATCH_NONOVERLAP_EN
            // Next match needs PAT_W fresh bits; stale window bits are harmless
            fill   <= hit ? '0 : fill_nxt;
`else
            fill   <= fill_nxt;
`endif
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// Programmable serial pattern-match controller.
// Ports:
//   clock, reset   rising-edge clock, async active-low reset
//   cfg_we         load cfg_pattern / cfg_limit (ignored while ARMED)
//   cfg_pattern    target pattern, compared MSB-first
//   cfg_limit      matches that end a run; 0 = unlimited
//   start          arm a run (pulse)
//   abort          cancel, return to IDLE (beats start and a same-cycle match)
//   datain         serial data bit
//   din_valid      datain qualifier
//   match          one-cycle pulse per detected match
//   busy           1 while ARMED
//   done           1 while DONE
//   match_count    matches in the current or last run (saturating)
// Build option: SEQ_MATCH_NONOVERLAP_EN selects non-overlapping detection.
module seq_match_ctrl
    import seq_match_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic             start,
    input  logic             abort,
    input  logic             datain,
    input  logic             din_valid,
    output logic             match,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count
);

    state_t           state;
    state_t           state_nxt;
    logic [PAT_W-1:0] pattern_r;
    logic [PAT_W-1:0] pattern_nxt;
    logic [CNT_W-1:0] limit_r;
    logic [CNT_W-1:0] limit_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] count_inc;
    logic             match_nxt;
    logic             shift_en;
    logic             clr;
    logic             hit;
    // Window is exposed for observation; the controller only needs hit
    logic [PAT_W-1:0] window_unused;

    // Kept outside the FSM block so hit never feeds back into its own enables
    assign shift_en = (state == ARMED) && din_valid && !abort;
    assign clr      = (state != ARMED) && start && !abort;

    seq_window_cmp #(
        .PAT_W (PAT_W)
    ) u_window (
        .clock    (clock),
        .reset    (reset),
        .shift_en (shift_en),
        .clr      (clr),
        .bit_in   (datain),
        .pattern  (pattern_r),
        .hit      (hit),
        .window   (window_unused)
    );

    // Next-state, counter and config update
    always_comb begin
        state_nxt   = state;
        match_nxt   = 1'b0;
        count_nxt   = match_count;
        pattern_nxt = pattern_r;
        limit_nxt   = limit_r;
        count_inc   = (match_count == '1) ? match_count : match_count + CNT_W'(1);

        if (cfg_we && (state != ARMED)) begin
            pattern_nxt = cfg_pattern;
            limit_nxt   = cfg_limit;
        end

        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_nxt = ARMED;
                        count_nxt = '0;
                    end
                end
                ARMED: begin
                    if (hit) begin
                        match_nxt = 1'b1;
                        count_nxt = count_inc;
                        if ((limit_r != '0) && (count_inc == limit_r)) begin
                            state_nxt = DONE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pattern_r   <= '0;
            limit_r     <= '0;
            match       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            match_count <= '0;
        end else begin
            state       <= state_nxt;
            pattern_r   <= pattern_nxt;
            limit_r     <= limit_nxt;
            match       <= match_nxt;
            busy        <= (state_nxt == ARMED);
            done        <= (state_nxt == DONE);
            match_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed self-checking bench for seq_match_ctrl (default overlapping build).
module tb_seq_match_ctrl;

    logic       clock;
    logic       reset;
    logic       cfg_we;
    logic [4:0] cfg_pattern;
    logic [7:0] cfg_limit;
    logic       start;
    logic       abort;
    logic       datain;
    logic       din_valid;
    logic       match;
    logic       busy;
    logic       done;
    logic [7:0] match_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Stream 1,1,1,0,1,1,1,0,1 sent from bit 8 down to bit 0
    logic [8:0] stream = 9'b111011101;
    logic [8:0] exp_m  = 9'b000010001;
    logic [4:0] pat5   = 5'b11101;

    seq_match_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_limit   (cfg_limit),
        .start       (start),
        .abort       (abort),
        .datain      (datain),
        .din_valid   (din_valid),
        .match       (match),
        .busy        (busy),
        .done        (done),
        .match_count (match_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic d, input logic v);
        datain    = d;
        din_valid = v;
        tick();
    endtask

    initial begin
        reset = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_limit = '0;
        start = 1'b0; abort = 1'b0; datain = 1'b0; din_valid = 1'b0;
        #3;
        chk("rst_match", 32'(match), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_count", 32'(match_count), 0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Overlapping count, unlimited
        cfg_pattern = 5'b11101; cfg_limit = 8'd0; cfg_we = 1'b1; tick(); cfg_we = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("arm_busy",  32'(busy), 1);
        chk("arm_count", 32'(match_count), 0);
        for (int i = 8; i >= 0; i--) begin
            send(stream[i], 1'b1);
            chk($sformatf("ovl_match_bit%0d", 9 - i), 32'(match), 32'(exp_m[i]));
            chk($sformatf("ovl_busy_bit%0d", 9 - i), 32'(busy), 1);
        end
        chk("ovl_count", 32'(match_count), 2);
        chk("ovl_done",  32'(done), 0);

        // start while ARMED is ignored
        din_valid = 1'b0; start = 1'b1; tick(); start = 1'b0;
        chk("restart_match", 32'(match), 0);
        chk("restart_count", 32'(match_count), 2);
        chk("restart_busy",  32'(busy), 1);

        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_busy",  32'(busy), 0);
        chk("abort_done",  32'(done), 0);
        chk("abort_count", 32'(match_count), 2);

        // Limit stop at 2
        cfg_limit = 8'd2; cfg_we = 1'b1; tick(); cfg_we = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("lim_count0", 32'(match_count), 0);
        for (int i = 8; i >= 0; i--) begin
            send(stream[i], 1'b1);
            chk($sformatf("lim_match_bit%0d", 9 - i), 32'(match), 32'(exp_m[i]));
        end
        chk("lim_done",  32'(done), 1);
        chk("lim_busy",  32'(busy), 0);
        chk("lim_count", 32'(match_count), 2);
        for (int i = 4; i >= 0; i--) begin
            send(pat5[i], 1'b1);
            chk($sformatf("lim_ignored_bit%0d", 5 - i), 32'(match), 0);
        end
        chk("lim_hold_count", 32'(match_count), 2);
        chk("lim_hold_done",  32'(done), 1);

        // Valid gaps with datain toggling; config reload allowed in DONE
        din_valid = 1'b0;
        cfg_limit = 8'd0; cfg_we = 1'b1; tick(); cfg_we = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("gap_done",  32'(done), 0);
        chk("gap_busy",  32'(busy), 1);
        chk("gap_count", 32'(match_count), 0);
        for (int i = 8; i >= 0; i--) begin
            send(stream[i], 1'b1);
            chk($sformatf("gap_match_bit%0d", 9 - i), 32'(match), 32'(exp_m[i]));
            send(~stream[i], 1'b0);
            chk($sformatf("gap_idle_after%0d", 9 - i), 32'(match), 0);
        end
        chk("gap_final_count", 32'(match_count), 2);

        // cfg_we while ARMED is ignored; window holds 11101 with fill full
        cfg_pattern = 5'b00000; cfg_limit = 8'd1; cfg_we = 1'b1; tick(); cfg_we = 1'b0;
        send(1'b1, 1'b1); chk("lock_b1", 32'(match), 0);
        send(1'b1, 1'b1); chk("lock_b2", 32'(match), 0);
        send(1'b0, 1'b1); chk("lock_b3", 32'(match), 0);
        send(1'b1, 1'b1); chk("lock_b4", 32'(match), 1);
        chk("lock_count", 32'(match_count), 3);
        chk("lock_busy",  32'(busy), 1);

        // Abort arriving with the match-completing bit
        send(1'b1, 1'b1); chk("abm_b1", 32'(match), 0);
        send(1'b1, 1'b1); chk("abm_b2", 32'(match), 0);
        send(1'b0, 1'b1); chk("abm_b3", 32'(match), 0);
        abort = 1'b1; send(1'b1, 1'b1); abort = 1'b0; din_valid = 1'b0;
        chk("abm_match", 32'(match), 0);
        chk("abm_busy",  32'(busy), 0);
        chk("abm_done",  32'(done), 0);
        chk("abm_count", 32'(match_count), 3);

        // Async reset mid-run, between edges
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 4; i >= 0; i--) send(pat5[i], 1'b1);
        din_valid = 1'b0;
        chk("prerst_match", 32'(match), 1);
        chk("prerst_count", 32'(match_count), 1);
        #1 reset = 1'b0;
        #1;
        chk("arst_match", 32'(match), 0);
        chk("arst_busy",  32'(busy), 0);
        chk("arst_done",  32'(done), 0);
        chk("arst_count", 32'(match_count), 0);
        #1 reset = 1'b1;

        // No start after reset: nothing may be reported
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 1'b1);
            chk($sformatf("postrst_match%0d", i), 32'(match), 0);
        end
        for (int i = 4; i >= 0; i--) send(pat5[i], 1'b1);
        chk("postrst_nostart_match", 32'(match), 0);
        chk("postrst_busy", 32'(busy), 0);

        din_valid = 1'b0;
        cfg_pattern = 5'b11101; cfg_limit = 8'd0; cfg_we = 1'b1; tick(); cfg_we = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            send(pat5[i], 1'b1);
            chk($sformatf("rearm_match_bit%0d", 5 - i), 32'(match), (i == 0) ? 32'd1 : 32'd0);
        end
        chk("rearm_count", 32'(match_count), 1);
        din_valid = 1'b0;
        tick();
        chk("rearm_pulse_end", 32'(match), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
